// File: rtl/key_expand_ctrl_if.sv
// Bundles the key-request, round-key output and shared subword-unit signals
// of the AES-128 key expansion controller.
interface key_expand_ctrl_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         done;
  logic         sw_req;
  logic [31:0]  sw_word;
  logic [31:0]  sw_result;
  logic         sw_ack;

  // Controller side.
  modport slave (
    input  start, key_in, sw_result, sw_ack,
    output busy, rk_valid, rk_idx, rk, done, sw_req, sw_word
  );

  // Requester / subword-unit side.
  modport master (
    output start, key_in, sw_result, sw_ack,
    input  busy, rk_valid, rk_idx, rk, done, sw_req, sw_word
  );
endinterface

// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion controller: produces round keys 0..10 one per
// subword transaction, borrowing an external shared SubWord unit.
module key_expand_ctrl (
  input  logic              clk,
  input  logic              rst,
  key_expand_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t       state_reg, state_next;
  logic [31:0]  w_reg [4];
  logic [31:0]  w_next [4];
  logic [7:0]   rcon_reg, rcon_next;
  logic [127:0] rk_reg, rk_next;
  logic [3:0]   rk_idx_reg, rk_idx_next;
  logic         rk_valid_reg, rk_valid_next;
  logic         done_reg, done_next;

  logic [31:0]  t_word;
  logic [31:0]  acc_word;
  logic [31:0]  w_new [4];
  logic [31:0]  key_word [4];
  logic [127:0] rk_new;
  logic [7:0]   rcon_xtime;
  logic [3:0]   rk_idx_inc;

  assign t_word     = bus.sw_result ^ {rcon_reg, 24'h0};
  assign rcon_xtime = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
  assign rk_idx_inc = rk_idx_reg + 4'd1;

  // Each new word is t XORed with the prefix of the old words, which keeps
  // the w0'..w3' chain free of combinational self-reference.
  always_comb begin
    acc_word = t_word;
    for (int i = 0; i < 4; i++) begin
      acc_word = acc_word ^ w_reg[i];
      w_new[i] = acc_word;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_words
      assign key_word[gi]                = bus.key_in[127-32*gi -: 32];
      assign rk_new[127-32*gi -: 32]     = w_new[gi];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    w_next        = w_reg;
    rcon_next     = rcon_reg;
    rk_next       = rk_reg;
    rk_idx_next   = rk_idx_reg;
    rk_valid_next = 1'b0;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          w_next        = key_word;
          rk_next       = bus.key_in;
          rk_idx_next   = 4'd0;
          rk_valid_next = 1'b1;
          rcon_next     = 8'h01;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (bus.sw_ack) begin
          w_next        = w_new;
          rk_next       = rk_new;
          rk_idx_next   = rk_idx_inc;
          rk_valid_next = 1'b1;
          rcon_next     = rcon_xtime;
          // done is registered alongside the round-10 key so both pulse together.
          if (rk_idx_inc == 4'd10) begin
            done_next  = 1'b1;
            state_next = FINISH;
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP:     state_next = REQ;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      for (int i = 0; i < 4; i++) w_reg[i] <= 32'h0;
      rcon_reg     <= 8'h0;
      rk_reg       <= 128'h0;
      rk_idx_reg   <= 4'd0;
      rk_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      w_reg        <= w_next;
      rcon_reg     <= rcon_next;
      rk_reg       <= rk_next;
      rk_idx_reg   <= rk_idx_next;
      rk_valid_reg <= rk_valid_next;
      done_reg     <= done_next;
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.sw_req   = (state_reg == REQ);
  assign bus.sw_word  = {w_reg[3][23:0], w_reg[3][31:24]};
  assign bus.rk       = rk_reg;
  assign bus.rk_idx   = rk_idx_reg;
  assign bus.rk_valid = rk_valid_reg;
  assign bus.done     = done_reg;

endmodule

// File: doc/key_expand_ctrl.md
KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 Parameters: none; AES-128 widths are fixed by the module.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to expand key_in; sampled only in IDLE.
REQ-005 key_in  input  128  cipher key; w0=key_in[127:96] .. w3=key_in[31:0]; sampled on the accepted start edge only.
REQ-006 busy  output  1  high while state != IDLE.
REQ-007 rk_valid  output  1  one-cycle pulse per round key.
REQ-008 rk_idx  output  4  round number 0..10 of rk.
REQ-009 rk  output  128  round key {w4r, w4r+1, w4r+2, w4r+3}.
REQ-010 done  output  1  one-cycle pulse, coincident with the round-10 rk_valid.
REQ-011 sw_req  output  1  request to the shared subword unit.
REQ-012 sw_word  output  32  subword input, RotWord(w3) = {w3[23:0], w3[31:24]}; stable while sw_req is high.
REQ-013 sw_result  input  32  subword output, byte order matching sw_word.
REQ-014 sw_ack  input  1  subword acknowledge; sw_result is valid in the cycle sw_ack is high.

Function
REQ-015 States SHALL be IDLE, REQ, GAP and FINISH, held in a registered state variable.
REQ-016 IDLE with start=1 SHALL, at that edge:
- load w0..w3 from key_in;
- set rk=key_in, rk_idx=0, rk_valid=1, rcon=8'h01;
- go to REQ.
REQ-017 REQ: sw_req SHALL be 1 (decoded from state); sw_req SHALL be 0 in every other state.
REQ-018 REQ with sw_ack=0 SHALL hold all state; the wait is unbounded.
REQ-019 REQ with sw_ack=1 SHALL, at that edge:
- t=sw_result^{rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2';
- rk={w0',w1',w2',w3'}; rk_idx+=1; rk_valid=1;
- rcon=xtime(rcon), i.e. the sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-020 After that capture, the next state SHALL be FINISH if the new rk_idx is 10, else GAP.
REQ-021 GAP SHALL last exactly one cycle with sw_req=0 (return-to-zero between transactions), then go to REQ.
REQ-022 FINISH SHALL last one cycle with done=1, then go to IDLE.
REQ-023 rk_valid and done SHALL be registered and high for exactly one cycle each.
REQ-024 sw_ack SHALL be ignored in IDLE, GAP and FINISH; the stale ack arriving in GAP SHALL NOT advance state.
REQ-025 start while busy=1 SHALL be ignored, with no effect on keys or timing.
REQ-026 rk and rk_idx SHALL hold their last values until the next accepted start or rst.
REQ-027 Latency with zero-wait subword (ack one cycle after req), start high in cycle 0:
- round 0 valid in cycle 1;
- round r valid in cycle 3r for r=1..10;
- done in cycle 30; busy high in cycles 1..30.

Reset
REQ-028 rst=1 SHALL force state=IDLE and rk, rk_idx, rk_valid, done, busy, sw_req, w0..w3 and rcon to 0, in any state.
REQ-029 rst SHALL take priority over start and sw_ack in the same cycle.
REQ-030 Reset mid-expansion SHALL abort the expansion with no further rk_valid; a start after reset SHALL begin a clean expansion.

Verification
REQ-031 Zero-wait expansion:
- key 2b7e151628aed2a6abf7158809cf4f3c;
- round 1 = a0fafe1788542cb123a339392a6c7605 in cycle 3;
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done in cycle 30;
- exactly 11 rk_valid pulses.
REQ-032 Ack delayed 3 cycles per request:
- sw_word stable and sw_req high throughout each wait;
- round keys identical to REQ-031; round r valid in cycle 5r.
REQ-033 start pulsed in cycle 10 of a busy expansion with a different key: output sequence and timing unchanged from REQ-031.
REQ-034 rst in cycle 12: cycle 13 shows busy=0, sw_req=0, rk=0, and no further rk_valid; a new start reproduces REQ-031.
REQ-035 Spurious sw_ack held high in IDLE and GAP: no state change, no extra rk_valid, and the rk_idx sequence is still 0..10.
REQ-036 Back-to-back: start in the cycle after FINISH is accepted, and round 0 equals the new key_in.
